shift_merge_exec: RTL and testbench
===================================

// Module: shift_merge_exec
// PURPOSE
//  Execute stage of the shift/merge path. Consumes the decoded controls (sa, pl, pr) produced by ShiftMergeDecode,
//  together with the operands, and computes EXTR / DEP / DSR results.
//  Two-stage pipeline with a valid/ready handshake on both sides and a synchronous flush; sits between operand fetch and writeback.
//  Bit numbering is big-endian: bit 0 = MSB, bit 31 = LSB.
// PARAMETERS
//  WIDTH   32  datapath width; only 32 is supported (5-bit sa/pl/pr)
//  TAG_W   5   width of the destination-register tag carried alongside the result
// PORTS
//  clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  flush      in   1      synchronous pipeline kill
//  in_valid   in   1      input beat valid
//  in_ready   out  1      stage can accept the input beat
//  op         in   2      0=EXTR, 1=DEP, 2=DSR, 3=reserved (result 0)
//  sext       in   1      EXTR: sign-fill from field MSB
//  zdep       in   1      DEP: zero background instead of b
//  sa         in   5      shift amount, from decode
//  pl         in   5      field left (MSB-side) position, from decode
//  pr         in   5      field right (LSB-side) position, from decode
//  a          in   WIDTH  source operand
//  b          in   WIDTH  DEP background / DSR low word
//  tag_in     in   TAG_W  destination tag, passed through
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  computed value
//  tag_out    out  TAG_W  tag of result
// BEHAVIOUR
//  Reset: s1_valid=0, out_valid=0, result=0, tag_out=0, in_ready=1. Reset mid-operation drops all in-flight beats.
//  Handshake:
//   - Transfer occurs when valid&&ready on the same rising edge.
//   - in_ready = !flush && (!s1_valid || !out_valid || out_ready).
//   - out_valid/result/tag_out hold stable while out_valid && !out_ready.
//  Latency: 2 cycles from input accept to out_valid. Throughput 1/cycle when out_ready=1.
//  Stage 1 (registered):
//   - rot = a rotated right by sa.
//   - dsr = low 32 bits of ({a,b} >> sa).
//   - mask M: bits pl..pr set when pl<=pr; all-zero when pl>pr.
//   - op, sext, zdep, b and tag are registered alongside.
//  Stage 2 (registered output):
//   - EXTR: (rot & M) | (fill & ~M); fill = all ones if sext && rot[pl], else 0.
//   - DEP: (rot & M) | (zdep ? 0 : b & ~M).
//   - DSR: dsr. sa=0 gives b.
//   - op=3: 0.
//  Advance: stage 2 loads when stage 1 is valid and (!out_valid || out_ready); stage 1 then loads the new input or clears.
//  Flush: s1_valid and out_valid are cleared at the next edge. A beat presented in the same cycle is not accepted (in_ready=0).
//  Flush has priority over every load.
//  Simultaneous output consume and input accept: both occur in one cycle with no bubble.
//  Boundaries:
//   - sa=0: rot=a.
//   - pl=pr: single-bit field.
//   - pl>pr: empty mask, so EXTR gives fill and DEP gives b (or 0 when zdep).
// TESTING
//  DSR: a=0x12345678, b=0x9ABCDEF0, sa=8 -> result 0x789ABCDE, 2 cycles after accept.
//  EXTR: a=0x00ABC000, sa=12, pl=20, pr=31, sext=0 -> 0x00000ABC.
//        Same control with a=0x00F00000, sext=1 -> 0xFFFFFF00.
//  DEP: a=0x5, b=0xFFFFFFFF, sa=28, pl=24, pr=27 -> 0xFFFFFF5F.
//       With zdep=1 -> 0x00000050. With pl=27, pr=24 -> 0xFFFFFFFF.
//  Backpressure: 4 back-to-back beats with out_ready=0:
//   - in_ready falls after 2 accepted beats and result holds.
//   - Raise out_ready: all beats emerge in order, one per cycle, none lost or duplicated.
//  Flush and reset:
//   - Assert flush with 2 beats in flight and in_valid=1 -> next cycle out_valid=0, s1 empty, the new beat is not accepted.
//   - Drop reset_n mid-stream -> outputs clear immediately, not on a clock edge.

Source files
------------

// File: rtl/shift_merge_exec.sv
// Execute stage of the shift/merge path: EXTR / DEP / DSR over a two-stage
// valid/ready pipeline. Bit numbering is big-endian (position 0 is the MSB).
module shift_merge_exec #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             sext,
  input  logic             zdep,
  input  logic [4:0]       sa,
  input  logic [4:0]       pl,
  input  logic [4:0]       pr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [1:0] OP_EXTR = 2'd0;
  localparam logic [1:0] OP_DEP  = 2'd1;
  localparam logic [1:0] OP_DSR  = 2'd2;

  logic [2*WIDTH-1:0] rotWide;
  logic [2*WIDTH-1:0] dsrWide;
  logic [WIDTH-1:0]   rotNext;
  logic [WIDTH-1:0]   maskNext;
  logic [4:0]         fieldMsbIdx;
  logic               fillBitNext;
  logic               advance;
  logic               accept;

  // Rotating {a,a} avoids a shift by the full width when sa is zero.
  assign rotWide     = {a, a} >> sa;
  assign dsrWide     = {a, b} >> sa;
  assign rotNext     = rotWide[WIDTH-1:0];
  assign fieldMsbIdx = 5'(WIDTH - 1) - pl;
  assign fillBitNext = rotNext[fieldMsbIdx];

  // Big-endian position gi maps to little-endian bit WIDTH-1-gi.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    localparam logic [4:0] POS = 5'(gi);
    assign maskNext[WIDTH-1-gi] = (pl <= pr) && (POS >= pl) && (POS <= pr);
  end

  logic             s1Valid;
  logic [1:0]       s1Op;
  logic             s1Sext;
  logic             s1Zdep;
  logic             s1FillBit;
  logic [WIDTH-1:0] s1Rot;
  logic [WIDTH-1:0] s1Dsr;
  logic [WIDTH-1:0] s1Mask;
  logic [WIDTH-1:0] s1B;
  logic [TAG_W-1:0] s1Tag;

  assign advance  = s1Valid && (!out_valid || out_ready);
  assign in_ready = !flush && (!s1Valid || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid   <= 1'b0;
      s1Op      <= '0;
      s1Sext    <= 1'b0;
      s1Zdep    <= 1'b0;
      s1FillBit <= 1'b0;
      s1Rot     <= '0;
      s1Dsr     <= '0;
      s1Mask    <= '0;
      s1B       <= '0;
      s1Tag     <= '0;
    end else if (flush) begin
      s1Valid <= 1'b0;
    end else if (accept) begin
      s1Valid   <= 1'b1;
      s1Op      <= op;
      s1Sext    <= sext;
      s1Zdep    <= zdep;
      s1FillBit <= fillBitNext;
      s1Rot     <= rotNext;
      s1Dsr     <= dsrWide[WIDTH-1:0];
      s1Mask    <= maskNext;
      s1B       <= b;
      s1Tag     <= tag_in;
    end else if (advance) begin
      s1Valid <= 1'b0;
    end
  end

  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] resNext;

  always_comb begin
    fill    = (s1Sext && s1FillBit) ? '1 : '0;
    resNext = '0;
    case (s1Op)
      OP_EXTR: resNext = (s1Rot & s1Mask) | (fill & ~s1Mask);
      OP_DEP:  resNext = (s1Rot & s1Mask) | (s1Zdep ? '0 : (s1B & ~s1Mask));
      OP_DSR:  resNext = s1Dsr;
      default: resNext = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      tag_out   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      result    <= resNext;
      tag_out   <= s1Tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_merge_exec.sv
// Bench for shift_merge_exec: spec vectors, a scoreboarded random stream,
// and directed latency / backpressure / flush / async-reset sequences.
module tb_shift_merge_exec;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        sext;
  logic        zdep;
  logic [4:0]  sa;
  logic [4:0]  pl;
  logic [4:0]  pr;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  tag_out;

  shift_merge_exec #(.WIDTH(32), .TAG_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sext(sext), .zdep(zdep), .sa(sa), .pl(pl), .pr(pr),
    .a(a), .b(b), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        sext;
    logic        zdep;
    logic [4:0]  sa;
    logic [4:0]  pl;
    logic [4:0]  pr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } sb_t;

  vec_t        vecs[14];
  sb_t         sbq[$];
  int          popCyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cycNo = 0;
  logic        lastAccept;
  logic [31:0] curExp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: sample handshakes at negedge+1, return at posedge+1.
  task automatic cycle();
    sb_t e;
    @(negedge clock); #1;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        e = sbq.pop_front();
        check("sb_result", result, e.res);
        check("sb_tag", 32'(tag_out), 32'(e.tag));
        popCyc.push_back(cycNo);
        $display("OUT cyc=%0d result=%h tag=%0d", cycNo, result, tag_out);
      end
    end
    lastAccept = in_valid && in_ready;
    if (lastAccept) sbq.push_back({curExp, tag_in});
    @(posedge clock); #1;
    cycNo++;
  endtask

  function automatic logic [31:0] model(input logic [1:0] mop, input logic msext, input logic mzdep,
                                        input logic [4:0] msa, input logic [4:0] mpl, input logic [4:0] mpr,
                                        input logic [31:0] ma, input logic [31:0] mb);
    logic [63:0] cat;
    logic [31:0] rot, m, r;
    logic fb;
    cat = {ma, mb} >> msa;
    for (int j = 0; j < 32; j++) rot[j] = ma[(j + int'(msa)) % 32];
    for (int i = 0; i < 32; i++) m[31-i] = (mpl <= mpr) && (i >= int'(mpl)) && (i <= int'(mpr));
    fb = rot[31 - int'(mpl)];
    case (mop)
      2'd0: r = (rot & m) | ((msext && fb) ? ~m : 32'h0);
      2'd1: r = (rot & m) | (mzdep ? 32'h0 : (mb & ~m));
      2'd2: r = cat[31:0];
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic setBeat(input vec_t v, input logic [4:0] t);
    op = v.op; sext = v.sext; zdep = v.zdep; sa = v.sa; pl = v.pl; pr = v.pr;
    a = v.a; b = v.b; tag_in = t; curExp = v.exp; in_valid = 1'b1;
  endtask

  task automatic sendBeat(input vec_t v, input logic [4:0] t, input bit randReady);
    int n;
    setBeat(v, t);
    n = 0;
    do begin
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end while (!lastAccept && n < 50);
    if (!lastAccept) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (sbq.size() > 0 && n < 50) begin cycle(); n++; end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] o, input logic s, input logic z,
                              input logic [4:0] vsa, input logic [4:0] vpl, input logic [4:0] vpr,
                              input logic [31:0] va, input logic [31:0] vb, input logic [31:0] ve);
    vec_t v;
    v.name = nm; v.op = o; v.sext = s; v.zdep = z; v.sa = vsa; v.pl = vpl; v.pr = vpr;
    v.a = va; v.b = vb; v.exp = ve;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   n0;
    vecs[0]  = mk("dsr8",        2'd2, 0, 0, 8,  0,  0,  32'h12345678, 32'h9ABCDEF0, 32'h789ABCDE);
    vecs[1]  = mk("extr_zero",   2'd0, 0, 0, 12, 20, 31, 32'h00ABC000, 32'h0,        32'h00000ABC);
    vecs[2]  = mk("extr_sext",   2'd0, 1, 0, 12, 20, 31, 32'h00F00000, 32'h0,        32'hFFFFFF00);
    vecs[3]  = mk("dep",         2'd1, 0, 0, 28, 24, 27, 32'h5,        32'hFFFFFFFF, 32'hFFFFFF5F);
    vecs[4]  = mk("dep_zdep",    2'd1, 0, 1, 28, 24, 27, 32'h5,        32'hFFFFFFFF, 32'h00000050);
    vecs[5]  = mk("dep_empty",   2'd1, 0, 0, 28, 27, 24, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFFF);
    vecs[6]  = mk("op3",         2'd3, 1, 0, 3,  0,  31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    vecs[7]  = mk("dsr_sa0",     2'd2, 0, 0, 0,  0,  0,  32'h11111111, 32'hCAFEBABE, 32'hCAFEBABE);
    vecs[8]  = mk("dsr_sa31",    2'd2, 0, 0, 31, 0,  0,  32'h80000001, 32'h80000000, 32'h00000003);
    vecs[9]  = mk("extr_1bit",   2'd0, 0, 0, 0,  31, 31, 32'hFFFFFFFF, 32'h0,        32'h00000001);
    vecs[10] = mk("extr_e_fill", 2'd0, 1, 0, 0,  20, 10, 32'h00000800, 32'h0,        32'hFFFFFFFF);
    vecs[11] = mk("extr_e_zero", 2'd0, 0, 0, 0,  20, 10, 32'h00000800, 32'h0,        32'h0);
    vecs[12] = mk("dep_e_zdep",  2'd1, 0, 1, 4,  9,  2,  32'h12345678, 32'hFFFFFFFF, 32'h0);
    vecs[13] = mk("extr_wrap",   2'd0, 0, 0, 4,  0,  7,  32'h0000000F, 32'h0,        32'hF0000000);

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; sext = 0; zdep = 0; sa = '0; pl = '0; pr = '0; a = '0; b = '0; tag_in = '0; curExp = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_tag", 32'(tag_out), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Latency: accept on edge 1, result visible after edge 2.
    out_ready = 1'b1;
    setBeat(vecs[0], 5'd1);
    cycle();
    in_valid = 1'b0;
    check("lat_accept", 32'(lastAccept), 32'h1);
    check("lat_edge1_valid", 32'(out_valid), 32'h0);
    cycle();
    check("lat_edge2_valid", 32'(out_valid), 32'h1);
    check("lat_edge2_result", result, 32'h789ABCDE);
    drain();

    // Spec/boundary table, back to back.
    foreach (vecs[i]) begin
      $display("VEC %s", vecs[i].name);
      sendBeat(vecs[i], 5'(i), 1'b0);
    end
    drain();

    // Backpressure: two beats fill the pipe, then the output holds.
    out_ready = 1'b0;
    n0 = popCyc.size();
    for (int i = 0; i < 4; i++) begin
      v = mk("bp", 2'd2, 0, 0, 0, 0, 0, 32'(i), 32'hB0 + 32'(i), 32'hB0 + 32'(i));
      if (i < 2) begin
        sendBeat(v, 5'(16 + i), 1'b0);
      end else begin
        setBeat(v, 5'(16 + i));
        if (i == 2) begin
          check("bp_in_ready", 32'(in_ready), 32'h0);
          cycle(); cycle();
          check("bp_hold_valid", 32'(out_valid), 32'h1);
          check("bp_hold_result", result, 32'hB0);
          check("bp_hold_tag", 32'(tag_out), 32'd16);
          out_ready = 1'b1;
        end
        cycle();
        check("bp_resume_accept", 32'(lastAccept), 32'h1);
      end
    end
    drain();
    check("bp_pop_count", 32'(popCyc.size() - n0), 32'd4);
    if (popCyc.size() >= 4)
      check("bp_one_per_cycle", 32'(popCyc[popCyc.size()-1] - popCyc[popCyc.size()-4]), 32'd3);

    // Flush with two beats in flight and a new beat offered.
    out_ready = 1'b0;
    sendBeat(vecs[3], 5'd20, 1'b0);
    sendBeat(vecs[4], 5'd21, 1'b0);
    setBeat(vecs[1], 5'd22);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'h0);
    cycle();
    check("flush_not_accepted", 32'(lastAccept), 32'h0);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'h0);
    sbq.delete();
    out_ready = 1'b1;
    cycle();
    check("flush_s1_empty", 32'(out_valid), 32'h0);
    sendBeat(vecs[1], 5'd22, 1'b0);
    drain();

    // Scoreboarded random stream with random output stalls.
    for (int i = 0; i < 150; i++) begin
      v = mk("rnd", 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom), $urandom, $urandom, 32'h0);
      v.exp = model(v.op, v.sext, v.zdep, v.sa, v.pl, v.pr, v.a, v.b);
      sendBeat(v, 5'(i), 1'b1);
      if ($urandom_range(0, 4) == 0) begin out_ready = 1'b1; cycle(); end
    end
    drain();

    // Asynchronous reset mid-stream, between clock edges.
    out_ready = 1'b0;
    sendBeat(vecs[7], 5'd7, 1'b0);
    sendBeat(vecs[8], 5'd8, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_result", result, 32'h0);
    check("arst_tag", 32'(tag_out), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    sbq.delete();
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b1;
    cycle();
    check("arst_pipe_empty", 32'(out_valid), 32'h0);
    sendBeat(vecs[2], 5'd2, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
